// File: rtl/ovc_state_tracker.sv
// ovc_state_tracker: per-output-VC busy/credit tracking between the VC allocator and switch allocator.
// Each VC is busy from grant until its tail has left and every downstream slot is credited back.
module ovc_state_tracker #(
    parameter int N     = 5,
    parameter int V     = 4,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*V-1:0]    ovc_alloc,
    input  logic [N*V-1:0]    flit_sent,
    input  logic [N*V-1:0]    tail_sent,
    input  logic [N*V-1:0]    credit_in,
    output logic [N*V-1:0]    ovc_free,
    output logic [N*V-1:0]    ovc_credit_ok,
    output logic [N*V*CW-1:0] ovc_credits,
    output logic [N*V-1:0]    ovc_err
);
    localparam int NV = N * V;
    localparam logic [1:0] IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2;
    localparam logic [CW:0] FULL = (CW + 1)'(DEPTH);

    for (genvar i = 0; i < NV; i++) begin : g_vc
        logic [1:0]    st, st_nxt;
        logic [CW-1:0] cnt, nxt;
        logic [CW:0]   sum;
        logic          snd, ovf, err;
        always_comb begin
            snd = flit_sent[i] && st == ACTIVE && cnt != '0;
            // one extra bit so an over-credit is visible before saturation
            sum = {1'b0, cnt} + (CW + 1)'(credit_in[i]) - (CW + 1)'(snd);
            ovf = sum > FULL;
            nxt = ovf ? FULL[CW-1:0] : sum[CW-1:0];
            st_nxt = st == IDLE   ? (ovc_alloc[i] ? ACTIVE : IDLE)
                   : st == ACTIVE ? (snd && tail_sent[i] ? (nxt == FULL[CW-1:0] ? IDLE : DRAIN) : ACTIVE)
                   : st == DRAIN  ? (nxt == FULL[CW-1:0] ? IDLE : DRAIN)
                   : IDLE;
        end
        always_ff @(posedge clk) begin
            if (rst) begin
                st  <= IDLE;
                cnt <= FULL[CW-1:0];
                err <= 1'b0;
            end else begin
                st  <= st_nxt;
                cnt <= nxt;
                err <= err | (ovc_alloc[i] && st != IDLE)
                           | (flit_sent[i] && (st != ACTIVE || cnt == '0)) | ovf;
            end
        end
        assign ovc_free[i]             = st == IDLE;
        assign ovc_credit_ok[i]        = cnt != '0;
        assign ovc_credits[i*CW +: CW] = cnt;
        assign ovc_err[i]              = err;
    end
endmodule

// File: tb/tb_ovc_state_tracker.sv
// tb_ovc_state_tracker: directed checks of VC state, credit and error tracking.
module tb_ovc_state_tracker;
    localparam int NV = 20, CW = 3;
    logic clk = 1'b0, rst = 1'b1;
    logic [NV-1:0] ovc_alloc = '0, flit_sent = '0, tail_sent = '0, credit_in = '0;
    logic [NV-1:0] ovc_free, ovc_credit_ok, ovc_err;
    logic [NV*CW-1:0] ovc_credits;
    int checks = 0, errors = 0;

    ovc_state_tracker dut (
        .clk(clk), .rst(rst), .ovc_alloc(ovc_alloc), .flit_sent(flit_sent),
        .tail_sent(tail_sent), .credit_in(credit_in), .ovc_free(ovc_free),
        .ovc_credit_ok(ovc_credit_ok), .ovc_credits(ovc_credits), .ovc_err(ovc_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ovc_alloc = '0; flit_sent = '0; tail_sent = '0; credit_in = '0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] cr(input int i);
        return ovc_credits[i*CW +: CW];
    endfunction

    initial begin
        cyc();
        rst = 1'b0;
        cyc(); cyc(); cyc();
        chk("rst_free", 64'(ovc_free), 64'hFFFFF);
        chk("rst_ok", 64'(ovc_credit_ok), 64'hFFFFF);
        chk("rst_credits", 64'(ovc_credits), 64'({20{3'd4}}));
        chk("rst_err", 64'(ovc_err), 64'h0);

        // VC6: four-flit packet, no credits until after the tail
        ovc_alloc[6] = 1'b1; cyc(); clr();
        chk("vc6_busy", 64'(ovc_free[6]), 64'h0);
        flit_sent[6] = 1'b1; cyc();
        chk("vc6_cnt3", 64'(cr(6)), 64'h3);
        cyc();
        chk("vc6_cnt2", 64'(cr(6)), 64'h2);
        cyc();
        chk("vc6_cnt1", 64'(cr(6)), 64'h1);
        tail_sent[6] = 1'b1; cyc(); clr();
        chk("vc6_cnt0", 64'(cr(6)), 64'h0);
        chk("vc6_ok0", 64'(ovc_credit_ok[6]), 64'h0);
        chk("vc6_drain", 64'(ovc_free[6]), 64'h0);
        cyc();
        credit_in[6] = 1'b1; cyc(); cyc(); cyc();
        chk("vc6_cnt3_drain", 64'(cr(6)), 64'h3);
        chk("vc6_still_busy", 64'(ovc_free[6]), 64'h0);
        cyc(); clr();
        chk("vc6_cnt4", 64'(cr(6)), 64'h4);
        chk("vc6_released", 64'(ovc_free[6]), 64'h1);
        chk("vc6_err", 64'(ovc_err[6]), 64'h0);

        // VC0: single-flit packet with immediate credit return
        ovc_alloc[0] = 1'b1; cyc(); clr();
        chk("vc0_busy", 64'(ovc_free[0]), 64'h0);
        flit_sent[0] = 1'b1; tail_sent[0] = 1'b1; credit_in[0] = 1'b1; cyc(); clr();
        chk("vc0_cnt", 64'(cr(0)), 64'h4);
        chk("vc0_free", 64'(ovc_free[0]), 64'h1);
        chk("vc0_err", 64'(ovc_err[0]), 64'h0);

        // VC3: exhaust credits, then send and re-grant illegally
        ovc_alloc[3] = 1'b1; cyc(); clr();
        flit_sent[3] = 1'b1; cyc(); cyc(); cyc(); cyc();
        chk("vc3_cnt0", 64'(cr(3)), 64'h0);
        chk("vc3_err_clean", 64'(ovc_err[3]), 64'h0);
        cyc(); clr();
        chk("vc3_cnt_hold", 64'(cr(3)), 64'h0);
        chk("vc3_err_send", 64'(ovc_err[3]), 64'h1);
        ovc_alloc[3] = 1'b1; cyc(); clr();
        chk("vc3_busy", 64'(ovc_free[3]), 64'h0);
        chk("vc3_err_alloc", 64'(ovc_err[3]), 64'h1);

        // VC19: over-credit while idle and full
        credit_in[19] = 1'b1; cyc(); clr();
        chk("vc19_cnt", 64'(cr(19)), 64'h4);
        chk("err_vec19", 64'(ovc_err), 64'h80008);

        // VC10: send in the same cycle as the grant is illegal
        ovc_alloc[10] = 1'b1; flit_sent[10] = 1'b1; cyc(); clr();
        chk("vc10_cnt", 64'(cr(10)), 64'h4);
        chk("vc10_busy", 64'(ovc_free[10]), 64'h0);
        chk("err_vec10", 64'(ovc_err), 64'h80408);

        // Reset mid-packet overrides every input
        ovc_alloc = '1; cyc(); clr();
        flit_sent = '1; cyc();
        chk("mid_cnt6", 64'(cr(6)), 64'h3);
        rst = 1'b1; credit_in = '1; ovc_alloc = '1; cyc();
        rst = 1'b0; clr();
        chk("rst2_free", 64'(ovc_free), 64'hFFFFF);
        chk("rst2_credits", 64'(ovc_credits), 64'({20{3'd4}}));
        chk("rst2_err", 64'(ovc_err), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ovc_state_tracker.md
# ovc_state_tracker

Output-side VC status and credit tracker, one instance per router, sitting between the VC allocator and the switch allocator. It consumes the per-output-VC allocation grants that `va_main` produces and marks each output VC busy from allocation until its packet's tail flit has left and every downstream buffer slot is credited back (conservative VC reallocation). It drives the free-VC mask that gates VA requests and the per-VC credit availability that gates SA requests. Every output VC is tracked independently; there is no cross-VC arbitration.

## Interface
Parameters:
- `N`, 5: router ports.
- `V`, 4: VCs per port.
- `DEPTH`, 4: downstream buffer slots per VC. Range 1..15.
- `CW`, $clog2(DEPTH+1): credit counter width.

Ports:
- `clk` input 1: the only clock; all state updates on its rising edge.
- `rst` input 1: synchronous reset, active-high.
- `ovc_alloc` input N*V: bit i=1 means output VC i (index = port*V+vc) was granted to a packet this cycle.
- `flit_sent` input N*V: a flit leaves through output VC i this cycle.
- `tail_sent` input N*V: that flit is a tail. Only meaningful when the same bit of `flit_sent` is set.
- `credit_in` input N*V: downstream returns one credit for VC i.
- `ovc_free` output N*V: VC i is IDLE and may be allocated.
- `ovc_credit_ok` output N*V: VC i credit count is greater than 0.
- `ovc_credits` output N*V*CW: credit count of VC i, in bits [i*CW +: CW].
- `ovc_err` output N*V: sticky protocol-violation flag per VC.

## Operation
- Each VC has a 2-bit state: IDLE, ACTIVE, DRAIN. It also has a CW-bit credit counter `cnt`, range 0..DEPTH.
- Effective send: `snd = flit_sent[i] & (state==ACTIVE) & (cnt!=0)`.
- Credit update: `cnt_next = cnt - snd + credit_in[i]`, saturating at DEPTH.
- A simultaneous send and credit leaves `cnt` unchanged.
- State transitions:
  - IDLE -> ACTIVE on `ovc_alloc[i]`.
  - ACTIVE -> IDLE on `snd & tail_sent[i]` when `cnt_next==DEPTH`.
  - ACTIVE -> DRAIN on `snd & tail_sent[i]` when `cnt_next<DEPTH`.
  - DRAIN -> IDLE when `cnt_next==DEPTH`.
  - Any other combination holds the current state.
- Error conditions. Each sets `ovc_err[i]`, which stays set until `rst`:
  - `ovc_alloc[i]` while not IDLE: the grant is ignored.
  - `flit_sent[i]` while not ACTIVE: the send is ignored and `cnt` is unchanged.
  - `flit_sent[i]` while `cnt==0`: the send is ignored.
  - `credit_in[i]` that would push `cnt` above DEPTH: `cnt` holds at DEPTH.
- `tail_sent` without `flit_sent` is ignored and is not an error.
- Outputs are registered state, not combinational from inputs:
  - `ovc_free = (state==IDLE)`.
  - `ovc_credit_ok = (cnt!=0)`.
  - `ovc_credits = cnt`.

## Timing
- Reset values, all VCs: state IDLE, `cnt`=DEPTH, `ovc_free` all 1, `ovc_credit_ok` all 1, `ovc_credits`=DEPTH per field, `ovc_err` all 0.
- `rst` overrides every other input in the same cycle, including mid-packet. Any ACTIVE or DRAIN VC returns to IDLE with full credits on the next edge.
- Allocation latency:
  - `ovc_alloc` in cycle t drops `ovc_free` at t+1.
  - The first legal `flit_sent` is at t+1.
  - A send in cycle t itself, while the VC is still IDLE, is an error.
- Credit latency: a send or credit in cycle t is visible on `ovc_credits`/`ovc_credit_ok` at t+1.
- Release latency: the VC shows `ovc_free`=1 in the cycle after the edge where `cnt` reaches DEPTH with the tail already sent.
- Minimum busy window for a single-flit packet with an immediate credit return: alloc at t, head/tail sent at t+1 with `credit_in`=1, free again at t+2.
- The VA must mask requests with `ovc_free` of the current cycle, so a VC is never re-granted in its release cycle.

## Test plan
- Reset, then idle for 3 cycles -> all `ovc_free`=1, every `ovc_credits` field =4, `ovc_err`=0.
- VC 6 (P1 VC2): alloc at t; sends at t+1..t+4 with tail at t+4; no credits -> counts 3,2,1,0, state DRAIN. Then 4 credits at t+6..t+9 -> `ovc_free[6]`=1 at t+10.
- VC 0: alloc at t; single-flit tail with `credit_in` in the same cycle t+1 -> `cnt` stays 4, `ovc_free[0]`=1 at t+2, no error.
- VC 3, ACTIVE with `cnt`=0: `flit_sent` -> `cnt` stays 0 and `ovc_err[3]`=1. A second `ovc_alloc[3]` while ACTIVE is also ignored, with `ovc_err[3]` still 1.
- VC 19 IDLE at `cnt`=4: `credit_in[19]` -> `cnt` stays 4, `ovc_err[19]`=1, other VCs unaffected.
- Allocate all 20 VCs; mid-packet, assert `rst` for one cycle together with `flit_sent` and `credit_in` all-ones -> next cycle all IDLE, counts 4, `ovc_err`=0.
